// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller.
//   - 6-bit stall encodings, one per requesting stage. Bit map of the vector:
//     0=pc, 1=if_id, 2=id_ex, 3=ex_mem, 4=mem_wb, 5=wb.
//   - mc_state_t: multi-cycle EX sequencer states.
//   - mc_len_norm: maps a requested op length of 0 to 1.
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  // Each encoding freezes the requesting stage and everything upstream of it.
  // The first register downstream of the frozen group loads a bubble.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  // A zero-length op still occupies EX for one cycle.
  function automatic logic [3:0] mc_len_norm(input logic [3:0] len);
    return (len == 4'd0) ? 4'd1 : len;
  endfunction

endpackage

// File: rtl/pipeline_mc_seq.sv
// -----------------------------------------------------------------------------
// pipeline_mc_seq
// Sequencer for multi-cycle EX operations. An op accepted at cycle t with
// length N holds EX during cycles t..t+N-1 and pulses o_done at t+N.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_start    pulse: EX begins a multi-cycle op (ignored while BUSY)
//   i_len      op length in cycles (0 treated as 1), sampled on accept only
//   i_flush    exception flush: aborts a running op without a done pulse
//   o_mc_hold  combinational: EX must hold this cycle
//   o_done     registered 1-cycle completion pulse
//   o_busy     registered: sequencer is in BUSY
// -----------------------------------------------------------------------------
module pipeline_mc_seq
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [3:0] i_len,
  input  logic       i_flush,
  output logic       o_mc_hold,
  output logic       o_done,
  output logic       o_busy
);

  mc_state_t  r_state;
  mc_state_t  w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [3:0] w_len_n;
  logic       w_accept;
  logic       r_done;
  logic       r_busy;

  // Next-state / counter logic. DONE behaves like IDLE for a new start so
  // back-to-back ops lose no cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_len_n     = mc_len_norm(i_len);
    case (r_state)
      IDLE, DONE: begin
        if (i_start && !i_flush) begin
          w_accept = 1'b1;
          if (w_len_n == 4'd1) begin
            w_state_nxt = DONE;
          end else begin
            w_cnt_nxt   = w_len_n - 4'd1;
            w_state_nxt = BUSY;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (i_flush) begin
          w_state_nxt = IDLE;
        end else if (r_cnt <= 4'd1) begin
          // <= rather than == so a corrupted zero count cannot wrap into a
          // 15-cycle hold.
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State, counter and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= (w_state_nxt == DONE);
      r_busy  <= (w_state_nxt == BUSY);
    end
  end

  assign o_mc_hold = w_accept | (r_state == BUSY);
  assign o_done    = r_done;
  assign o_busy    = r_busy;

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush controller for the 5-stage pipeline. Merges per-stage
// stall requests into a 6-bit stall vector (highest stage wins), forwards the
// exception flush (which overrides all stalls), sequences multi-cycle EX ops
// and runs a sticky stall watchdog.
// Optional feature macro: PIPE_PERF_EN (builds the 32-bit perf counters; when
// undefined both perf outputs are tied to zero and no counter flops exist).
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   stallreq_if/id/ex/mem  per-stage stall requests
//   ex_mc_start, ex_mc_len multi-cycle EX op start pulse and length
//   exc_flush        exception/redirect flush
//   stall[5:0]       combinational stall vector
//   flush            combinational flush
//   ex_mc_done       registered op-complete pulse
//   ex_mc_busy       sequencer busy
//   stall_timeout    sticky: stall[0] held STALL_TIMEOUT consecutive cycles
//   perf_stall_cyc   cycles with stall[0]=1
//   perf_flush_cnt   cycles with flush=1
// -----------------------------------------------------------------------------
module pipeline_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1000,
  parameter int WD_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        ex_mc_start,
  input  logic [3:0]  ex_mc_len,
  input  logic        exc_flush,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        ex_mc_done,
  output logic        ex_mc_busy,
  output logic        stall_timeout,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
);

  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_TIMEOUT);

  logic            w_mc_hold;
  logic [5:0]      w_stall;
  logic [WD_W-1:0] r_wd_cnt;
  logic [WD_W-1:0] w_wd_nxt;
  logic            r_timeout;

  pipeline_mc_seq u_mc_seq (
    .clk       (clk),
    .rst       (rst),
    .i_start   (ex_mc_start),
    .i_len     (ex_mc_len),
    .i_flush   (exc_flush),
    .o_mc_hold (w_mc_hold),
    .o_done    (ex_mc_done),
    .o_busy    (ex_mc_busy)
  );

  // Priority encode of stall requests; a flush empties the pipe so it must
  // never be blocked by a stall.
  always_comb begin
    w_stall = STALL_NONE;
    if (exc_flush) begin
      w_stall = STALL_NONE;
    end else if (stallreq_mem) begin
      w_stall = STALL_MEM;
    end else if (stallreq_ex || w_mc_hold) begin
      w_stall = STALL_EX;
    end else if (stallreq_id) begin
      w_stall = STALL_ID;
    end else if (stallreq_if) begin
      w_stall = STALL_IF;
    end else begin
      w_stall = STALL_NONE;
    end
  end

  assign stall = w_stall;
  assign flush = exc_flush;

  // Watchdog next count: saturating count of consecutive stall[0] cycles.
  always_comb begin
    w_wd_nxt = r_wd_cnt;
    if (!w_stall[0]) begin
      w_wd_nxt = '0;
    end else if (r_wd_cnt >= WD_LIMIT) begin
      w_wd_nxt = WD_LIMIT;
    end else begin
      w_wd_nxt = r_wd_cnt + WD_W'(1);
    end
  end

  // Watchdog counter and sticky timeout flag (set on the edge the count
  // reaches the limit, cleared only by reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt  <= w_wd_nxt;
      r_timeout <= r_timeout | (w_wd_nxt == WD_LIMIT);
    end
  end

  assign stall_timeout = r_timeout;

`ifdef PIPE_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Free-running performance counters; wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if (w_stall[0]) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (exc_flush) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_stall_cyc = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`else
  assign perf_stall_cyc = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule
